// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between instruction fetch and load/store, with fixed wait states.
// Define MEM_ARB_STARVE_GUARD_EN to force a waiting fetch through after STARVE_LIMIT load/store grants.
module mem_port_arbiter #(
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_rd,
   input  logic [15:0] pc_addr,
   input  logic        ldst_rd,
   input  logic        ldst_wr,
   input  logic [15:0] ldst_addr,
   input  logic [15:0] ldst_wdata,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   output logic        fetch_done,
   output logic [15:0] fetch_data,
   output logic        ldst_done,
   output logic [15:0] ldst_data,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, FETCH, LDST, DONE} state_t;

   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

   state_t     state;
   logic [2:0] wait_cnt;
   logic       ldst_req;
   logic       grant_ldst;

   assign ldst_req = ldst_rd | ldst_wr;
   assign stall    = (pc_rd | ldst_req) & ~(fetch_done | ldst_done);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;

   // Load/store loses its priority once a waiting fetch has been passed over STARVE_LIMIT times.
   assign grant_ldst = ldst_req & ~(pc_rd & (starve_cnt == SW'(STARVE_LIMIT)));

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (grant_ldst) begin
            if (!pc_rd)
               starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
               starve_cnt <= starve_cnt + SW'(1);
         end else if (pc_rd) begin
            starve_cnt <= '0;
         end
      end
   end
`else
   assign grant_ldst = ldst_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_wdata  <= '0;
         fetch_done <= 1'b0;
         ldst_done  <= 1'b0;
         fetch_data <= '0;
         ldst_data  <= '0;
      end else begin
         fetch_done <= 1'b0;
         ldst_done  <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= WAIT_LOAD;
               if (grant_ldst) begin
                  state     <= LDST;
                  mem_addr  <= ldst_addr;
                  mem_rd    <= ldst_rd;
                  mem_wr    <= ldst_wr;
                  mem_wdata <= ldst_wdata;
               end else if (pc_rd) begin
                  state    <= FETCH;
                  mem_addr <= pc_addr;
                  mem_rd   <= 1'b1;
                  mem_wr   <= 1'b0;
               end
            end
            FETCH, LDST: begin
               if (wait_cnt == 3'd0) begin
                  state  <= DONE;
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (state == FETCH) begin
                     fetch_data <= mem_rdata;
                     fetch_done <= 1'b1;
                  end else begin
                     // A store leaves the last load result untouched.
                     if (mem_rd)
                        ldst_data <= mem_rdata;
                     ldst_done <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int W     = 1;
   localparam int LIMIT = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        pc_rd, ldst_rd, ldst_wr;
   logic [15:0] pc_addr, ldst_addr, ldst_wdata, mem_rdata;
   logic [15:0] mem_addr, mem_wdata, fetch_data, ldst_data;
   logic        mem_rd, mem_wr, fetch_done, ldst_done, stall;

   logic        z_pc_rd, z_ldst_rd, z_ldst_wr;
   logic [15:0] z_pc_addr, z_ldst_addr, z_ldst_wdata, z_mem_rdata;
   logic [15:0] z_mem_addr, z_mem_wdata, z_fetch_data, z_ldst_data;
   logic        z_mem_rd, z_mem_wr, z_fetch_done, z_ldst_done, z_stall;

   int vectors = 0;
   int miscompares = 0;

   mem_port_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .pc_rd(pc_rd), .pc_addr(pc_addr),
      .ldst_rd(ldst_rd), .ldst_wr(ldst_wr), .ldst_addr(ldst_addr), .ldst_wdata(ldst_wdata),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .fetch_done(fetch_done), .fetch_data(fetch_data),
      .ldst_done(ldst_done), .ldst_data(ldst_data), .stall(stall));

   mem_port_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(LIMIT)) dut0 (
      .clk(clk), .reset(reset), .pc_rd(z_pc_rd), .pc_addr(z_pc_addr),
      .ldst_rd(z_ldst_rd), .ldst_wr(z_ldst_wr), .ldst_addr(z_ldst_addr), .ldst_wdata(z_ldst_wdata),
      .mem_rdata(z_mem_rdata), .mem_addr(z_mem_addr), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
      .mem_wdata(z_mem_wdata), .fetch_done(z_fetch_done), .fetch_data(z_fetch_data),
      .ldst_done(z_ldst_done), .ldst_data(z_ldst_data), .stall(z_stall));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pc_rd = 1'b1; pc_addr = 16'h1357; ldst_rd = 1'b1; ldst_wr = 1'b0;
      ldst_addr = 16'h2468; ldst_wdata = 16'h9999; mem_rdata = 16'hFFFF;
      z_pc_rd = 1'b0; z_pc_addr = 16'h0; z_ldst_rd = 1'b1; z_ldst_wr = 1'b0;
      z_ldst_addr = 16'h1111; z_ldst_wdata = 16'h0; z_mem_rdata = 16'hFFFF;
      step(); step();
      pc_rd = 1'b0; ldst_rd = 1'b0; z_ldst_rd = 1'b0; mem_rdata = 16'h0; z_mem_rdata = 16'h0;
      #1;
      vectors++;
      if ({mem_rd, mem_wr, fetch_done, ldst_done, stall, mem_addr, mem_wdata, fetch_data, ldst_data} !== 69'h0) begin
         miscompares++;
         $display("FAIL reset_main: got rd%b wr%b fd%b ld%b st%b a%h wd%h fdat%h ldat%h, want all 0",
                  mem_rd, mem_wr, fetch_done, ldst_done, stall, mem_addr, mem_wdata, fetch_data, ldst_data);
      end
      vectors++;
      if ({z_mem_rd, z_mem_wr, z_ldst_done, z_mem_addr, z_ldst_data} !== 35'h0) begin
         miscompares++;
         $display("FAIL reset_w0: got rd%b wr%b ld%b a%h ldat%h, want all 0",
                  z_mem_rd, z_mem_wr, z_ldst_done, z_mem_addr, z_ldst_data);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_fetch();
      pc_rd = 1'b1; pc_addr = 16'h0040; mem_rdata = 16'h0;
      #1;
      vectors++;
      if ({stall, mem_rd} !== 2'b10) begin
         miscompares++;
         $display("FAIL fetch_c0: got stall%b rd%b want stall1 rd0", stall, mem_rd);
      end
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) pc_addr = 16'hFFFF;
         mem_rdata = (c == 2) ? 16'hA5A5 : 16'h0000;
         #1;
         vectors++;
         if ({mem_rd, mem_wr, fetch_done, stall} !== {c <= 2, 1'b0, c == 3, c <= 2}) begin
            miscompares++;
            $display("FAIL fetch_ctl c%0d: got rd%b wr%b done%b stall%b want rd%b wr0 done%b stall%b",
                     c, mem_rd, mem_wr, fetch_done, stall, c <= 2, c == 3, c <= 2);
         end
         if (c <= 2) begin
            vectors++;
            if (mem_addr !== 16'h0040) begin
               miscompares++;
               $display("FAIL fetch_addr c%0d: got %h want 0040", c, mem_addr);
            end
         end
         if (c >= 3) begin
            vectors++;
            if (fetch_data !== 16'hA5A5) begin
               miscompares++;
               $display("FAIL fetch_data c%0d: got %h want a5a5", c, fetch_data);
            end
            pc_rd = 1'b0;
         end
      end
   endtask

   task automatic test_store();
      ldst_wr = 1'b1; ldst_addr = 16'h0100; ldst_wdata = 16'h1234; mem_rdata = 16'hBEEF;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL store_stall: got %b want 1", stall);
      end
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) begin ldst_addr = 16'h7777; ldst_wdata = 16'h8888; end
         #1;
         vectors++;
         if ({mem_rd, mem_wr, ldst_done, ldst_data} !== {1'b0, c <= 2, c == 3, 16'h0000}) begin
            miscompares++;
            $display("FAIL store_ctl c%0d: got rd%b wr%b done%b ldat%h want rd0 wr%b done%b ldat0000",
                     c, mem_rd, mem_wr, ldst_done, ldst_data, c <= 2, c == 3);
         end
         if (c <= 2) begin
            vectors++;
            if ({mem_addr, mem_wdata} !== {16'h0100, 16'h1234}) begin
               miscompares++;
               $display("FAIL store_bus c%0d: got a%h wd%h want a0100 wd1234", c, mem_addr, mem_wdata);
            end
         end
         if (c == 3) ldst_wr = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      pc_rd = 1'b1; pc_addr = 16'h0200; ldst_rd = 1'b1; ldst_addr = 16'h0300; mem_rdata = 16'h0;
      for (int c = 1; c <= 8; c++) begin
         step();
         mem_rdata = (c == 2) ? 16'h1111 : (c == 6) ? 16'h2222 : 16'h0000;
         #1;
         vectors++;
         if ({mem_rd, ldst_done, fetch_done} !== {(c == 1) || (c == 2) || (c == 5) || (c == 6), c == 3, c == 7}) begin
            miscompares++;
            $display("FAIL simul_ctl c%0d: got rd%b ldone%b fdone%b", c, mem_rd, ldst_done, fetch_done);
         end
         if (c == 1 || c == 5) begin
            vectors++;
            if (mem_addr !== ((c == 1) ? 16'h0300 : 16'h0200)) begin
               miscompares++;
               $display("FAIL simul_addr c%0d: got %h want %h", c, mem_addr, (c == 1) ? 16'h0300 : 16'h0200);
            end
         end
         if (c == 3) begin
            vectors++;
            if (ldst_data !== 16'h1111) begin
               miscompares++;
               $display("FAIL simul_ldata: got %h want 1111", ldst_data);
            end
            ldst_rd = 1'b0;
         end
         if (c == 7) begin
            vectors++;
            if (fetch_data !== 16'h2222) begin
               miscompares++;
               $display("FAIL simul_fdata: got %h want 2222", fetch_data);
            end
            pc_rd = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_access();
      pc_rd = 1'b1; pc_addr = 16'h0440; mem_rdata = 16'hCCCC;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      vectors++;
      if ({mem_rd, mem_wr, fetch_done, ldst_done, mem_addr, mem_wdata, fetch_data, ldst_data} !== 68'h0) begin
         miscompares++;
         $display("FAIL midreset_clear: got rd%b wr%b fd%b ld%b a%h wd%h fdat%h ldat%h want all 0",
                  mem_rd, mem_wr, fetch_done, ldst_done, mem_addr, mem_wdata, fetch_data, ldst_data);
      end
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_stall: got %b want 1", stall);
      end
      for (int c = 4; c <= 7; c++) begin
         step();
         mem_rdata = (c == 5) ? 16'h5A5A : 16'h0000;
         #1;
         vectors++;
         if ({mem_rd, fetch_done} !== {(c == 4) || (c == 5), c == 6}) begin
            miscompares++;
            $display("FAIL midreset_restart c%0d: got rd%b done%b want rd%b done%b",
                     c, mem_rd, fetch_done, (c == 4) || (c == 5), c == 6);
         end
         if (c == 6) begin
            vectors++;
            if (fetch_data !== 16'h5A5A) begin
               miscompares++;
               $display("FAIL midreset_data: got %h want 5a5a", fetch_data);
            end
            pc_rd = 1'b0;
         end
      end
   endtask

   task automatic test_back_to_back_w0();
      z_ldst_rd = 1'b1; z_ldst_addr = 16'h0A00;
      for (int c = 1; c <= 6; c++) begin
         step();
         z_mem_rdata = (c == 1) ? 16'h0101 : (c == 4) ? 16'h0404 : 16'h0000;
         if (c == 2) z_ldst_addr = 16'h0B00;
         #1;
         vectors++;
         if ({z_mem_rd, z_ldst_done} !== {(c == 1) || (c == 4), (c == 2) || (c == 5)}) begin
            miscompares++;
            $display("FAIL b2b_ctl c%0d: got rd%b done%b want rd%b done%b",
                     c, z_mem_rd, z_ldst_done, (c == 1) || (c == 4), (c == 2) || (c == 5));
         end
         if (c == 1 || c == 4) begin
            vectors++;
            if (z_mem_addr !== ((c == 1) ? 16'h0A00 : 16'h0B00)) begin
               miscompares++;
               $display("FAIL b2b_addr c%0d: got %h want %h", c, z_mem_addr, (c == 1) ? 16'h0A00 : 16'h0B00);
            end
         end
         if (c == 2 || c == 5) begin
            vectors++;
            if (z_ldst_data !== ((c == 2) ? 16'h0101 : 16'h0404)) begin
               miscompares++;
               $display("FAIL b2b_data c%0d: got %h want %h", c, z_ldst_data, (c == 2) ? 16'h0101 : 16'h0404);
            end
         end
         if (c == 5) z_ldst_rd = 1'b0;
      end
   endtask

   task automatic test_starve();
      bit want_f;
      pc_rd = 1'b1; pc_addr = 16'h0F00; ldst_rd = 1'b1; ldst_addr = 16'h0E00;
      for (int c = 1; c <= 32; c++) begin
         step();
         #1;
         want_f = GUARD && ((((c - 1) / 4) % 4) == 3);
         case ((c - 1) % 4)
            0, 1: begin
               vectors++;
               if ({mem_rd, mem_addr} !== {1'b1, want_f ? 16'h0F00 : 16'h0E00}) begin
                  miscompares++;
                  $display("FAIL starve_grant c%0d: got rd%b a%h want rd1 a%h",
                           c, mem_rd, mem_addr, want_f ? 16'h0F00 : 16'h0E00);
               end
            end
            2: begin
               vectors++;
               if ({fetch_done, ldst_done} !== {want_f, !want_f}) begin
                  miscompares++;
                  $display("FAIL starve_done c%0d: got fd%b ld%b want fd%b ld%b",
                           c, fetch_done, ldst_done, want_f, !want_f);
               end
            end
            default: begin
               vectors++;
               if ({mem_rd, fetch_done, ldst_done} !== 3'b000) begin
                  miscompares++;
                  $display("FAIL starve_idle c%0d: got rd%b fd%b ld%b want 000", c, mem_rd, fetch_done, ldst_done);
               end
            end
         endcase
      end
      pc_rd = 1'b0; ldst_rd = 1'b0;
   endtask

   // Model: each grant at cycle g owns the port for cycles g+1..g+1+W, signals done at g+2+W,
   // and the next grant can happen no earlier than the cycle after done.
   task automatic test_random();
      int pc_st = 0, ls_st = 0, kind = 0, g = 0, free_at = 0, starve = 0;
      bit ls_wr = 1'b0, exp_s, exp_fd, exp_ld;
      logic [15:0] a_lat = '0, wd_lat = '0, cap = '0, m_fd = '0, m_ld = '0;
      logic [36:0] got, want;
      pc_rd = 1'b0; ldst_rd = 1'b0; ldst_wr = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         step();
         exp_fd = (kind == 1) && (t == g + W + 2);
         exp_ld = (kind >= 2) && (t == g + W + 2);
         exp_s  = (kind != 0) && (t >= g + 1) && (t <= g + 1 + W);
         case (pc_st)
            0: if ($urandom_range(2) == 0) begin
                  pc_st = 1; pc_rd = 1'b1; pc_addr = 16'($urandom);
               end else pc_rd = 1'b0;
            1: if ($urandom_range(9) == 0) begin pc_st = 0; pc_rd = 1'b0; end
            default: begin pc_addr = 16'($urandom); pc_rd = ($urandom_range(4) != 0); end
         endcase
         case (ls_st)
            0: if ($urandom_range(1) == 0) begin
                  ls_st = 1; ls_wr = ($urandom_range(1) == 1);
                  ldst_rd = !ls_wr; ldst_wr = ls_wr;
                  ldst_addr = 16'($urandom); ldst_wdata = 16'($urandom);
               end else begin ldst_rd = 1'b0; ldst_wr = 1'b0; end
            1: if ($urandom_range(9) == 0) begin ls_st = 0; ldst_rd = 1'b0; ldst_wr = 1'b0; end
            default: begin
               ldst_addr = 16'($urandom); ldst_wdata = 16'($urandom);
               if ($urandom_range(4) == 0) begin ldst_rd = 1'b0; ldst_wr = 1'b0; end
               else begin ldst_rd = !ls_wr; ldst_wr = ls_wr; end
            end
         endcase
         mem_rdata = 16'($urandom);
         #1;
         if (exp_fd) m_fd = cap;
         if (exp_ld && kind == 2) m_ld = cap;
         got  = {mem_rd, mem_wr, fetch_done, ldst_done, stall, fetch_data, ldst_data};
         want = {exp_s && kind != 3, exp_s && kind == 3, exp_fd, exp_ld,
                 (pc_rd | ldst_rd | ldst_wr) & ~(exp_fd | exp_ld), m_fd, m_ld};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL random_out t%0d: got %h want %h (rd,wr,fd,ld,stall,fdata,ldata)", t, got, want);
         end
         if (exp_s) begin
            vectors++;
            if ({mem_addr, (kind == 3) ? mem_wdata : 16'h0} !== {a_lat, (kind == 3) ? wd_lat : 16'h0}) begin
               miscompares++;
               $display("FAIL random_bus t%0d: got a%h wd%h want a%h wd%h", t, mem_addr, mem_wdata, a_lat, wd_lat);
            end
         end
         if (exp_s && t == g + 1 + W) cap = mem_rdata;
         if (exp_fd || exp_ld) begin
            if (exp_fd) pc_st = 0; else ls_st = 0;
            kind = 0;
            free_at = t + 1;
         end else if (kind == 0 && t >= free_at) begin
            if ((ldst_rd | ldst_wr) && !(GUARD && pc_rd && starve == LIMIT)) begin
               kind = ldst_rd ? 2 : 3; g = t; a_lat = ldst_addr; wd_lat = ldst_wdata; ls_st = 2;
               starve = pc_rd ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            end else if (pc_rd) begin
               kind = 1; g = t; a_lat = pc_addr; pc_st = 2; starve = 0;
            end
         end
      end
      pc_rd = 1'b0; ldst_rd = 1'b0; ldst_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_simultaneous();
      test_reset_mid_access();
      test_back_to_back_w0();
      test_starve();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
